// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave endpoint: oversamples sck/csn/si in the clk domain, deserializes MSB-first
// 32-bit words into rx_data (valid/ready) and serializes a held tx word back on so.
// Optional feature macro: SPI_SLAVE_ECHO_EN (underrun loads return the last received word).
module spi_slave_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sck,
  input  logic        csn,
  input  logic        si,
  output logic        so,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
  output logic        rx_overrun,
  output logic        tx_underrun
);

  typedef enum logic [1:0] {
    StWait,
    StIdle,
    StShift
  } state_e;

  // Cycles after reset until the synchronizer chains hold real pin samples.
  localparam logic [2:0] WarmCycles = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, si_sync_q;
  logic                   sck_prev_q, csn_prev_q;
  logic [2:0]             warm_q;
  logic                   warm_done;
  logic                   sck_s, csn_s, si_s;
  logic                   sck_rise, sck_fall, csn_rise, csn_fall;

  state_e      state_q, state_d;
  logic [31:0] shift_rx_q, shift_rx_d;
  logic [31:0] shift_tx_q, shift_tx_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        held_q, held_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        tx_underrun_q, tx_underrun_d;
  // word_done: a word completed, the next sck fall reloads shift_tx.
  logic        word_done_q, word_done_d;
  // Boundary reloads only show the word on so; consuming it (or flagging an underrun) is
  // deferred to the next sck rise so a frame ending on a word boundary consumes nothing.
  logic        peek_pend_q, peek_pend_d;
  logic        peek_had_q, peek_had_d;
  logic [31:0] fill_word;
  logic [31:0] load_word;
  logic [31:0] rx_word;
  logic        tx_hs;
`ifdef SPI_SLAVE_ECHO_EN
  logic [31:0] last_rx_q, last_rx_d;
`endif

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign csn_s = csn_sync_q[SYNC_STAGES-1];
  assign si_s  = si_sync_q[SYNC_STAGES-1];

  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;
  assign warm_done = (warm_q == WarmCycles);

`ifdef SPI_SLAVE_ECHO_EN
  assign fill_word = last_rx_q;
`else
  assign fill_word = 32'h0000_0000;
`endif
  assign load_word = held_q ? hold_q : fill_word;
  assign rx_word   = {shift_rx_q[30:0], si_s};
  assign tx_hs     = tx_valid & ~held_q;

  // Pin synchronizers; csn idles high so its chain resets to 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_sync_q <= '0;
      csn_sync_q <= '1;
      si_sync_q  <= '0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], csn};
      si_sync_q  <= {si_sync_q[SYNC_STAGES-2:0], si};
    end
  end

  // Edge-detect registers and post-reset warm-up counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_prev_q <= 1'b0;
      csn_prev_q <= 1'b1;
      warm_q     <= 3'd0;
    end else begin
      sck_prev_q <= sck_s;
      csn_prev_q <= csn_s;
      if (!warm_done) begin
        warm_q <= warm_q + 3'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StWait;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, shift datapath, handshakes and status pulses.
  always_comb begin
    state_d       = state_q;
    shift_rx_d    = shift_rx_q;
    shift_tx_d    = shift_tx_q;
    bit_cnt_d     = bit_cnt_q;
    hold_d        = hold_q;
    held_d        = held_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = 1'b0;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    word_done_d   = word_done_q;
    peek_pend_d   = peek_pend_q;
    peek_had_d    = peek_had_q;
`ifdef SPI_SLAVE_ECHO_EN
    last_rx_d     = last_rx_q;
`endif

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StWait: begin
        // Only a csn seen high after warm-up proves no frame is in flight.
        if (warm_done && csn_s) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (csn_fall) begin
          state_d     = StShift;
          bit_cnt_d   = 5'd0;
          shift_tx_d  = load_word;
          word_done_d = 1'b0;
          peek_pend_d = 1'b0;
          if (held_q) begin
            held_d = 1'b0;
          end else begin
            tx_underrun_d = 1'b1;
          end
        end
      end

      StShift: begin
        if (csn_rise) begin
          state_d     = StIdle;
          word_done_d = 1'b0;
          peek_pend_d = 1'b0;
          if (bit_cnt_q != 5'd0) begin
            frame_err_d = 1'b1;
          end
        end else if (sck_rise) begin
          shift_rx_d = rx_word;
          bit_cnt_d  = bit_cnt_q + 5'd1;
          if (peek_pend_q) begin
            peek_pend_d = 1'b0;
            if (peek_had_q) begin
              held_d = 1'b0;
            end else begin
              tx_underrun_d = 1'b1;
            end
          end
          if (bit_cnt_q == 5'd31) begin
            word_done_d = 1'b1;
`ifdef SPI_SLAVE_ECHO_EN
            last_rx_d   = rx_word;
`endif
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
            end else begin
              rx_overrun_d = 1'b1;
            end
          end
        end else if (sck_fall) begin
          if (word_done_q) begin
            shift_tx_d  = load_word;
            word_done_d = 1'b0;
            peek_pend_d = 1'b1;
            peek_had_d  = held_q;
          end else begin
            shift_tx_d = {shift_tx_q[30:0], 1'b0};
          end
        end
      end

      default: begin
        state_d = StWait;
      end
    endcase

    // Only possible while empty, so it never races a consuming load.
    if (tx_hs) begin
      hold_d = tx_data;
      held_d = 1'b1;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_rx_q    <= 32'h0000_0000;
      shift_tx_q    <= 32'h0000_0000;
      bit_cnt_q     <= 5'd0;
      hold_q        <= 32'h0000_0000;
      held_q        <= 1'b0;
      rx_data_q     <= 32'h0000_0000;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      word_done_q   <= 1'b0;
      peek_pend_q   <= 1'b0;
      peek_had_q    <= 1'b0;
    end else begin
      shift_rx_q    <= shift_rx_d;
      shift_tx_q    <= shift_tx_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_q        <= hold_d;
      held_q        <= held_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      word_done_q   <= word_done_d;
      peek_pend_q   <= peek_pend_d;
      peek_had_q    <= peek_had_d;
    end
  end

`ifdef SPI_SLAVE_ECHO_EN
  // Snapshot of the last completed receive word for echo on underrun.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_rx_q <= 32'h0000_0000;
    end else begin
      last_rx_q <= last_rx_d;
    end
  end
`endif

  assign so          = shift_tx_q[31];
  assign tx_ready    = ~held_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule
